// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, funct7 selectors, 5-bit ALU control codes
// and the issue-buffer occupancy states.
package alu_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00100;
   localparam logic [4:0] ALU_SLL  = 5'b10110;
   localparam logic [4:0] ALU_SLT  = 5'b11011;
   localparam logic [4:0] ALU_SLTU = 5'b11010;
   localparam logic [4:0] ALU_XOR  = 5'b10100;
   localparam logic [4:0] ALU_SRL  = 5'b11000;
   localparam logic [4:0] ALU_SRA  = 5'b11001;
   localparam logic [4:0] ALU_OR   = 5'b10010;
   localparam logic [4:0] ALU_AND  = 5'b10000;

   localparam logic [4:0] ALU_MUL    = 5'b01001;
   localparam logic [4:0] ALU_MULH   = 5'b01011;
   localparam logic [4:0] ALU_MULHSU = 5'b01010;
   localparam logic [4:0] ALU_MULHU  = 5'b01000;
   localparam logic [4:0] ALU_DIV    = 5'b01101;
   localparam logic [4:0] ALU_DIVU   = 5'b01100;
   localparam logic [4:0] ALU_REM    = 5'b01111;
   localparam logic [4:0] ALU_REMU   = 5'b01110;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

   // Base-ISA code for a funct3 when funct7 is all zeros (ADD, not SUB/SRA).
   function automatic logic [4:0] base_code(input logic [2:0] funct3);
      case (funct3)
         3'b000:  base_code = ALU_ADD;
         3'b001:  base_code = ALU_SLL;
         3'b010:  base_code = ALU_SLT;
         3'b011:  base_code = ALU_SLTU;
         3'b100:  base_code = ALU_XOR;
         3'b101:  base_code = ALU_SRL;
         3'b110:  base_code = ALU_OR;
         default: base_code = ALU_AND;
      endcase
   endfunction

   function automatic logic [4:0] muldiv_code(input logic [2:0] funct3);
      case (funct3)
         3'b000:  muldiv_code = ALU_MUL;
         3'b001:  muldiv_code = ALU_MULH;
         3'b010:  muldiv_code = ALU_MULHSU;
         3'b011:  muldiv_code = ALU_MULHU;
         3'b100:  muldiv_code = ALU_DIV;
         3'b101:  muldiv_code = ALU_DIVU;
         3'b110:  muldiv_code = ALU_REM;
         default: muldiv_code = ALU_REMU;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32IM decode into ALU operands, control code and shift amount.
module alu_op_decode
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [31:0]      instr_i,
   input  logic [WIDTH-1:0] pc_i,
   input  logic [WIDTH-1:0] rs1_i,
   input  logic [WIDTH-1:0] rs2_i,
   output logic [WIDTH-1:0] operand_a_o,
   output logic [WIDTH-1:0] operand_b_o,
   output logic [4:0]       alu_control_o,
   output logic [SHW-1:0]   shift_amount_o,
   output logic             illegal_o
);

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [WIDTH-1:0] imm_i;
   logic [WIDTH-1:0] imm_u;
   logic             unused_rd;

   assign opcode    = instr_i[6:0];
   assign funct3    = instr_i[14:12];
   assign funct7    = instr_i[31:25];
   assign imm_i     = WIDTH'($signed(instr_i[31:20]));
   assign imm_u     = WIDTH'($signed({instr_i[31:12], 12'b0}));
   assign unused_rd = ^instr_i[11:7];

   always_comb begin
      operand_a_o    = '0;
      operand_b_o    = '0;
      alu_control_o  = ALU_ADD;
      shift_amount_o = '0;
      illegal_o      = 1'b0;
      case (opcode)
         OP: begin
            operand_a_o    = rs1_i;
            operand_b_o    = rs2_i;
            shift_amount_o = rs2_i[SHW-1:0];
            case (funct7)
               F7_BASE:   alu_control_o = base_code(funct3);
               F7_MULDIV: alu_control_o = muldiv_code(funct3);
               F7_ALT: begin
                  if (funct3 == 3'b000)      alu_control_o = ALU_SUB;
                  else if (funct3 == 3'b101) alu_control_o = ALU_SRA;
                  else                       illegal_o     = 1'b1;
               end
               default:   illegal_o = 1'b1;
            endcase
         end
         OP_IMM: begin
            operand_a_o    = rs1_i;
            operand_b_o    = imm_i;
            shift_amount_o = SHW'(instr_i[24:20]);
            case (funct3)
               3'b001: begin
                  if (funct7 == F7_BASE) alu_control_o = ALU_SLL;
                  else                   illegal_o     = 1'b1;
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     alu_control_o = ALU_SRL;
                  else if (funct7 == F7_ALT) alu_control_o = ALU_SRA;
                  else                       illegal_o     = 1'b1;
               end
               default: alu_control_o = base_code(funct3);
            endcase
         end
         LUI: begin
            operand_b_o = imm_u;
         end
         AUIPC: begin
            operand_a_o = pc_i;
            operand_b_o = imm_u;
         end
         default: illegal_o = 1'b1;
      endcase
      // Illegal encodings always present a clean all-zero payload downstream.
      if (illegal_o) begin
         operand_a_o    = '0;
         operand_b_o    = '0;
         alu_control_o  = ALU_ADD;
         shift_amount_o = '0;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes one instruction per cycle and holds it in a 2-entry
// skid FIFO in front of the ALU; in_ready is registered from next occupancy.
//
// state | meaning
// EMPTY | no entries, out_valid low
// ONE   | one entry at head
// FULL  | two entries, in_ready low
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [WIDTH-1:0]         in_pc,
   input  logic [WIDTH-1:0]         in_rs1,
   input  logic [WIDTH-1:0]         in_rs2,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_operand_a,
   output logic [WIDTH-1:0]         out_operand_b,
   output logic [4:0]               out_alu_control,
   output logic [$clog2(WIDTH)-1:0] out_shift_amount,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_illegal
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] dec_a;
   logic [WIDTH-1:0] dec_b;
   logic [4:0]       dec_code;
   logic [SHW-1:0]   dec_shamt;
   logic             dec_illegal;

   alu_op_decode #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_decode (
      .instr_i        (in_instr),
      .pc_i           (in_pc),
      .rs1_i          (in_rs1),
      .rs2_i          (in_rs2),
      .operand_a_o    (dec_a),
      .operand_b_o    (dec_b),
      .alu_control_o  (dec_code),
      .shift_amount_o (dec_shamt),
      .illegal_o      (dec_illegal)
   );

   fifo_state_t      state_q, state_d;
   logic             head_q, tail_q;
   logic             in_ready_q;
   logic [WIDTH-1:0] a_q     [2];
   logic [WIDTH-1:0] b_q     [2];
   logic [4:0]       code_q  [2];
   logic [SHW-1:0]   shamt_q [2];
   logic [TAG_W-1:0] tag_q   [2];
   logic             ill_q   [2];
   logic             push, pop;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);

   // A flush cycle neither pushes nor pops; it simply empties the buffer.
   assign push = in_valid && in_ready_q && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
               if (push && !pop)      state_d = FULL;
               else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         in_ready_q <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            a_q[i]     <= '0;
            b_q[i]     <= '0;
            code_q[i]  <= ALU_ADD;
            shamt_q[i] <= '0;
            tag_q[i]   <= '0;
            ill_q[i]   <= 1'b0;
         end
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
         if (flush) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
         end else begin
            if (push) begin
               a_q[tail_q]     <= dec_a;
               b_q[tail_q]     <= dec_b;
               code_q[tail_q]  <= dec_code;
               shamt_q[tail_q] <= dec_shamt;
               tag_q[tail_q]   <= in_tag;
               ill_q[tail_q]   <= dec_illegal;
               tail_q          <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
         end
      end
   end

   assign out_operand_a    = a_q[head_q];
   assign out_operand_b    = b_q[head_q];
   assign out_alu_control  = code_q[head_q];
   assign out_shift_amount = shamt_q[head_q];
   assign out_tag          = tag_q[head_q];
   assign out_illegal      = ill_q[head_q];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, back-pressure, FIFO
// ordering, flush and asynchronous reset.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_rs1 = '0;
   logic [31:0] in_rs2 = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_operand_a;
   logic [31:0] out_operand_b;
   logic [4:0]  out_alu_control;
   logic [4:0]  out_shift_amount;
   logic [4:0]  out_tag;
   logic        out_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRAI  = 32'h4030D093;
   localparam logic [31:0] I_DIVU  = 32'h0220D1B3;
   localparam logic [31:0] I_BAD   = 32'h0000007F;
   localparam logic [31:0] I_LUI   = 32'h12345037;
   localparam logic [31:0] I_AUIPC = 32'hFFFFF017;
   localparam logic [31:0] I_ADDIM = 32'hFFF08093;
   localparam logic [31:0] I_SLLIX = 32'h40109093;

   alu_issue_stage #(.WIDTH(32), .TAG_W(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_instr         (in_instr),
      .in_pc            (in_pc),
      .in_rs1           (in_rs1),
      .in_rs2           (in_rs2),
      .in_tag           (in_tag),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_operand_a    (out_operand_a),
      .out_operand_b    (out_operand_b),
      .out_alu_control  (out_alu_control),
      .out_shift_amount (out_shift_amount),
      .out_tag          (out_tag),
      .out_illegal      (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_tag   = tag;
   endtask

   // One accepted transfer with out_ready high; returns just after the accepting edge.
   task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag);
      @(negedge clk);
      out_ready = 1'b1;
      drive(instr, pc, rs1, rs2, tag);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_code", {27'b0, out_alu_control}, 32'd0);
      check("rst_a", out_operand_a, 32'd0);
      check("rst_illegal", {31'b0, out_illegal}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(I_ADD, 32'h0, 32'd5, 32'd7, 5'd3);
      check("add_valid", {31'b0, out_valid}, 32'd1);
      check("add_code", {27'b0, out_alu_control}, 32'h00);
      check("add_a", out_operand_a, 32'd5);
      check("add_b", out_operand_b, 32'd7);
      check("add_shamt", {27'b0, out_shift_amount}, 32'd7);
      check("add_tag", {27'b0, out_tag}, 32'd3);

      issue(I_SUB, 32'h0, 32'd3, 32'd9, 5'd4);
      check("sub_code", {27'b0, out_alu_control}, 32'h04);
      check("sub_a", out_operand_a, 32'd3);
      check("sub_b", out_operand_b, 32'd9);

      issue(I_SRAI, 32'h0, 32'h80000000, 32'hDEAD, 5'd1);
      check("srai_code", {27'b0, out_alu_control}, 32'h19);
      check("srai_shamt", {27'b0, out_shift_amount}, 32'd3);
      check("srai_b", out_operand_b, 32'h403);
      check("srai_a", out_operand_a, 32'h80000000);

      issue(I_DIVU, 32'h0, 32'd100, 32'd7, 5'd2);
      check("divu_code", {27'b0, out_alu_control}, 32'h0C);
      check("divu_illegal", {31'b0, out_illegal}, 32'd0);

      issue(I_BAD, 32'h40, 32'h1234, 32'h5678, 5'd5);
      check("bad_illegal", {31'b0, out_illegal}, 32'd1);
      check("bad_code", {27'b0, out_alu_control}, 32'h00);
      check("bad_a", out_operand_a, 32'd0);
      check("bad_b", out_operand_b, 32'd0);

      issue(I_LUI, 32'h40, 32'h1234, 32'h5678, 5'd6);
      check("lui_a", out_operand_a, 32'd0);
      check("lui_b", out_operand_b, 32'h12345000);

      issue(I_AUIPC, 32'h100, 32'h1234, 32'h5678, 5'd7);
      check("auipc_a", out_operand_a, 32'h100);
      check("auipc_b", out_operand_b, 32'hFFFFF000);

      issue(I_ADDIM, 32'h0, 32'd10, 32'd0, 5'd8);
      check("addi_neg_b", out_operand_b, 32'hFFFFFFFF);
      check("addi_neg_code", {27'b0, out_alu_control}, 32'h00);

      issue(I_SLLIX, 32'h0, 32'd10, 32'd0, 5'd9);
      check("slli_bad_f7", {31'b0, out_illegal}, 32'd1);

      @(posedge clk);
      #1;
      check("drained", {31'b0, out_valid}, 32'd0);

      // Back-pressure: three offered, two absorbed.
      @(negedge clk);
      out_ready = 1'b0;
      drive(I_ADD, 32'h0, 32'd11, 32'd0, 5'd11);
      @(posedge clk);
      #1;
      check("bp_ready_one", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd12, 32'd0, 5'd12);
      @(posedge clk);
      #1;
      check("bp_ready_low", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd13, 32'd0, 5'd13);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_tag", {27'b0, out_tag}, 32'd11);
         check("bp_hold_a", out_operand_a, 32'd11);
         check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_pop1_tag", {27'b0, out_tag}, 32'd12);
      check("bp_pop1_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("bp_pop2_tag", {27'b0, out_tag}, 32'd13);
      check("bp_pop2_a", out_operand_a, 32'd13);
      check("bp_pop2_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_empty", {31'b0, out_valid}, 32'd0);

      // Steady push+pop at occupancy one.
      @(negedge clk);
      out_ready = 1'b0;
      drive(I_ADD, 32'h0, 32'd0, 32'd0, 5'd0);
      @(posedge clk);
      #1;
      check("pp_first_tag", {27'b0, out_tag}, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         drive(I_ADD, 32'h0, 32'(k * 3), 32'd0, 5'(k));
         @(posedge clk);
         #1;
         check("pp_tag", {27'b0, out_tag}, 32'(k));
         check("pp_a", out_operand_a, 32'(k * 3));
         check("pp_ready", {31'b0, in_ready}, 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pp_empty", {31'b0, out_valid}, 32'd0);

      // Flush while FULL with in_valid high.
      @(negedge clk);
      out_ready = 1'b0;
      drive(I_ADD, 32'h0, 32'd1, 32'd0, 5'd21);
      @(posedge clk);
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd2, 32'd0, 5'd22);
      @(posedge clk);
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd3, 32'd0, 5'd23);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush_full_valid", {31'b0, out_valid}, 32'd0);
      check("flush_full_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("flush_full_dropped", {31'b0, out_valid}, 32'd0);

      // Flush at ONE with a push offered: push must be discarded.
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd4, 32'd0, 5'd24);
      @(posedge clk);
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd5, 32'd0, 5'd25);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush_one_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("flush_one_dropped", {31'b0, out_valid}, 32'd0);

      // Post-flush entry appears at the head with correct data.
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd6, 32'd0, 5'd26);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("post_flush_tag", {27'b0, out_tag}, 32'd26);

      // Async reset mid-cycle, no clock edge in between.
      @(negedge clk);
      drive(I_ADD, 32'h0, 32'd7, 32'd0, 5'd27);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("pre_rst_ready", {31'b0, in_ready}, 32'd0);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {31'b0, out_valid}, 32'd0);
      check("async_rst_ready", {31'b0, in_ready}, 32'd1);
      check("async_rst_tag", {27'b0, out_tag}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("after_rst_empty", {31'b0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
